// File: rtl/fifo_rd_ctrl.sv
// Read-side controller that prefetches FIFO words into a 2-entry skid buffer for a valid/ready sink.
// Define FIFO_RD_COUNT_EN to build the rd_count delivery counter; otherwise rd_count is tied to 0.
module fifo_rd_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [FIFO_WIDTH-1:0] head_q, head_d;
    logic [FIFO_WIDTH-1:0] tail_q, tail_d;
    logic                  err_q, err_d;
    logic [1:0]            pending;
    logic                  pop;
    logic                  push;

    // Words owed to the buffer: stored ones plus the read still in flight.
    assign pending       = occ_q + {1'b0, inflight_q};
    assign m_valid       = rst_n && (occ_q != 2'd0);
    assign pop           = m_valid && m_ready;
    assign push          = inflight_q && !fifo_underflow;
    assign fifo_rd_en    = rst_n && (state_q == RUN) && !fifo_empty &&
                           ((pending < 2'd2) || ((pending == 2'd2) && pop));
    assign m_data        = head_q;
    assign busy          = rst_n && (state_q != IDLE);
    assign underflow_err = err_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        state_d = state_q;
        err_d   = err_q | (inflight_q & fifo_underflow);

        // Pop shifts the tail forward first, so a push lands in the slot left free.
        if (pop) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
        end
        if (push) begin
            if (occ_d == 2'd0) begin
                head_d = fifo_data_out;
            end else begin
                tail_d = fifo_data_out;
            end
            occ_d = occ_d + 2'd1;
        end

        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            err_q      <= err_d;
        end
    end

`ifdef FIFO_RD_COUNT_EN
    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign rd_count = count_q;
`else
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized bench for fifo_rd_ctrl: a queue-level FIFO and delivery model predicts every output each cycle.
module tb_fifo_rd_ctrl;

    localparam int W       = 16;
    localparam int CW      = 16;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data_out;
    logic          fifo_underflow;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [CW-1:0] rd_count;
    logic          underflow_err;
    logic          busy;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_underflow(fifo_underflow),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .rd_count      (rd_count),
        .underflow_err (underflow_err),
        .busy          (busy)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: source FIFO contents, words held for the sink, and the read in flight.
    logic [W-1:0]  fifoQ[$];
    logic [W-1:0]  bufQ[$];
    bit            inflightV;
    bit            inflightDrop;
    logic [W-1:0]  inflightWord;
    int            mode;
    bit            errModel;
    logic [CW-1:0] cntModel;

    // Observations of the DUT itself, used by the directed scenario checks.
    int cyc;
    int firstRdCyc;
    int firstValidCyc;
    int obsXferCycles[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic clearObs();
        firstRdCyc    = -1;
        firstValidCyc = -1;
        obsXferCycles.delete();
    endtask

    // One clock cycle: drive inputs, predict and check outputs, then advance the model over the edge.
    task automatic applyStimulus(input bit enV, input bit readyV, input bit rstV,
                                 input bit emptyV, input bit ufV, input bit spurV);
        bit            expRdEn;
        bit            expValid;
        bit            expBusy;
        bit            xfer;
        bit            idleReady;
        int            pendingWords;
        logic [CW-1:0] expCnt;

        en             = enV;
        m_ready        = readyV;
        rst_n          = rstV;
        fifo_empty     = emptyV || (fifoQ.size() == 0);
        fifo_underflow = inflightV ? inflightDrop : spurV;
        fifo_data_out  = inflightV ? inflightWord : W'($urandom);
        #3;

        pendingWords = bufQ.size() + (inflightV ? 1 : 0);
        expValid     = rstV && (bufQ.size() != 0);
        xfer         = expValid && readyV;
        expRdEn      = rstV && (mode == M_RUN) && !fifo_empty &&
                       ((pendingWords < 2) || ((pendingWords == 2) && xfer));
        expBusy      = rstV && (mode != M_IDLE);
`ifdef FIFO_RD_COUNT_EN
        expCnt = cntModel;
`else
        expCnt = '0;
`endif

        checkOutput("fifo_rd_en", 32'(fifo_rd_en), 32'(expRdEn));
        checkOutput("m_valid", 32'(m_valid), 32'(expValid));
        if (expValid) checkOutput("m_data", 32'(m_data), 32'(bufQ[0]));
        checkOutput("busy", 32'(busy), 32'(expBusy));
        checkOutput("underflow_err", 32'(underflow_err), 32'(errModel));
        checkOutput("rd_count", 32'(rd_count), 32'(expCnt));

        if (fifo_rd_en === 1'b1 && firstRdCyc < 0) firstRdCyc = cyc;
        if (m_valid === 1'b1 && firstValidCyc < 0) firstValidCyc = cyc;
        if (m_valid === 1'b1 && readyV) obsXferCycles.push_back(cyc);

        @(posedge clk);
        #1;
        cyc++;

        if (!rstV) begin
            bufQ.delete();
            inflightV = 1'b0;
            mode      = M_IDLE;
            errModel  = 1'b0;
            cntModel  = '0;
        end else begin
            idleReady = (bufQ.size() == 0) && !inflightV;
            if (xfer) begin
                void'(bufQ.pop_front());
                cntModel = cntModel + 1'b1;
            end
            if (inflightV) begin
                if (inflightDrop) errModel = 1'b1;
                else bufQ.push_back(inflightWord);
            end
            case (mode)
                M_IDLE:  if (enV) mode = M_RUN;
                M_RUN:   if (!enV) mode = M_DRAIN;
                default: begin
                    if (enV) mode = M_RUN;
                    else if (idleReady) mode = M_IDLE;
                end
            endcase
            inflightV = expRdEn;
            if (expRdEn) begin
                inflightWord = fifoQ.pop_front();
                inflightDrop = ufV;
            end
        end
    endtask

    task automatic preload(input int n, input bit sequential);
        fifoQ.delete();
        for (int i = 1; i <= n; i++) fifoQ.push_back(sequential ? W'(i) : W'($urandom));
    endtask

    initial begin
        int dropCyc;
        int afterDrop;

        rst_n          = 1'b0;
        en             = 1'b0;
        m_ready        = 1'b0;
        fifo_empty     = 1'b1;
        fifo_underflow = 1'b0;
        fifo_data_out  = '0;
        cyc            = 0;
        inflightV      = 1'b0;
        inflightDrop   = 1'b0;
        inflightWord   = '0;
        mode           = M_IDLE;
        errModel       = 1'b0;
        cntModel       = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then a spurious underflow pulse while nothing is in flight.
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_m_data", 32'(m_data), 32'h0);
        repeat (3) applyStimulus(0, 1, 1, 0, 0, 1);

        // Preloaded 1..8 streamed at full rate.
        preload(8, 1'b1);
        clearObs();
        repeat (14) applyStimulus(1, 1, 1, 0, 0, 0);
        checkOutput("s1_latency", 32'(firstValidCyc - firstRdCyc), 32'd2);
        checkOutput("s1_words", 32'(obsXferCycles.size()), 32'd8);
        if (obsXferCycles.size() == 8)
            checkOutput("s1_back_to_back", 32'(obsXferCycles[7] - obsXferCycles[0]), 32'd7);
        repeat (4) applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("s1_idle", 32'(busy), 32'h0);

        // Sink stalls for 5 cycles mid-stream.
        preload(20, 1'b0);
        repeat (3) applyStimulus(1, 1, 1, 0, 0, 0);
        repeat (5) applyStimulus(1, 0, 1, 0, 0, 0);
        repeat (22) applyStimulus(1, 1, 1, 0, 0, 0);
        repeat (4) applyStimulus(0, 1, 1, 0, 0, 0);

        // Enable dropped in steady streaming: two more words, then idle.
        preload(10, 1'b0);
        repeat (6) applyStimulus(1, 1, 1, 0, 0, 0);
        clearObs();
        dropCyc = cyc;
        repeat (6) applyStimulus(0, 1, 1, 0, 0, 0);
        afterDrop = 0;
        foreach (obsXferCycles[i]) if (obsXferCycles[i] > dropCyc) afterDrop++;
        checkOutput("drain_words", 32'(afterDrop), 32'd2);
        checkOutput("drain_idle", 32'(busy), 32'h0);

        // FIFO empty flag toggling every cycle.
        preload(30, 1'b0);
        for (int i = 0; i < 24; i++) applyStimulus(1, 1'($urandom), 1, 1'(i % 2 == 0), 0, 0);
        repeat (8) applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("toggle_no_err", 32'(underflow_err), 32'h0);

        // Underflow flagged on one in-flight word.
        preload(8, 1'b0);
        applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 1, 0);
        repeat (10) applyStimulus(1, 1, 1, 0, 0, 0);
        repeat (4) applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("uf_sticky", 32'(underflow_err), 32'h1);

        // One-cycle reset with the buffer full.
        preload(16, 1'b0);
        repeat (6) applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst_busy_next", 32'(busy), 32'h0);
        checkOutput("rst_valid_next", 32'(m_valid), 32'h0);
        repeat (14) applyStimulus(1, 1, 1, 0, 0, 0);

        // Random traffic with occasional underflow and reset.
        for (int i = 0; i < 400; i++) begin
            if (fifoQ.size() < 4) fifoQ.push_back(W'($urandom));
            applyStimulus(($urandom_range(0, 7) != 0), 1'($urandom), ($urandom_range(0, 63) != 0),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), 1'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of rd_count.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port en, input, 1, enables fetching words from the FIFO.
REQ-006 SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-007 SHALL have port fifo_data_out, input, FIFO_WIDTH, FIFO read data, valid 1 cycle after an accepted rd_en.
REQ-008 SHALL have port fifo_underflow, input, 1, FIFO registered underflow flag.
REQ-009 SHALL have port fifo_rd_en, output, 1, combinational read request to the FIFO.
REQ-010 SHALL have port m_valid, output, 1, downstream word valid.
REQ-011 SHALL have port m_ready, input, 1, downstream ready.
REQ-012 SHALL have port m_data, output, FIFO_WIDTH, downstream word.
REQ-013 SHALL have port rd_count, output, CNT_WIDTH, count of words delivered downstream.
REQ-014 SHALL have port underflow_err, output, 1, sticky protocol-error flag.
REQ-015 SHALL have port busy, output, 1, high when state is not IDLE.

Function
REQ-016 SHALL use a 2-entry output buffer (occ 0..2) plus a 1-bit inflight flag set in the cycle after fifo_rd_en=1.
REQ-017 SHALL drive fifo_rd_en=1 only when state=RUN, fifo_empty=0, and either occ+inflight<2 or (occ+inflight=2 and m_valid&m_ready).
REQ-018 SHALL write fifo_data_out into the buffer tail on the cycle inflight=1; a simultaneous pop and push SHALL leave occ unchanged.
REQ-019 SHALL drive m_valid=(occ!=0) and m_data=buffer head; a transfer occurs when m_valid&m_ready, and m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-020 SHALL deliver words in exact FIFO order, with no loss and no duplication.
REQ-021 SHALL sustain 1 word/cycle with m_ready held at 1 and the FIFO non-empty; first m_valid arrives 2 cycles after the first fifo_rd_en.
REQ-022 SHALL implement FSM states IDLE, RUN, DRAIN with these transitions: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->RUN when en=1; DRAIN->IDLE when occ=0 and inflight=0.
REQ-023 SHALL issue no fifo_rd_en in IDLE or DRAIN; DRAIN still captures inflight data and delivers buffered words.
REQ-024 SHALL set underflow_err=1 when fifo_underflow=1 in a cycle where inflight=1; it stays set until reset.
REQ-025 SHALL discard an inflight word whose fifo_underflow=1 and not count it.
REQ-026 SHALL increment rd_count by 1 per downstream transfer, wrapping from 2^CNT_WIDTH-1 to 0.

Reset
REQ-027 SHALL, on rising clk with rst_n=0, set state=IDLE, occ=0, inflight=0, m_data=0, rd_count=0 and underflow_err=0.
REQ-028 SHALL force fifo_rd_en=0, m_valid=0 and busy=0 combinationally while rst_n=0.
REQ-029 SHALL discard any inflight or buffered word on reset mid-operation; after reset release, the first delivered word is the next word read from the FIFO.

Configuration
REQ-030 SHALL compile the rd_count counter in only when macro FIFO_RD_COUNT_EN is defined; without it, rd_count SHALL be tied to 0 with no counter register, and all other behaviour is unchanged.

Verification
REQ-031 SHALL cover: FIFO preloaded with 0x0001..0x0008, en=1, m_ready=1 -> m_data 0x0001..0x0008 on 8 consecutive cycles, first m_valid 2 cycles after first fifo_rd_en, rd_count=8.
REQ-032 SHALL cover: m_ready=0 for 5 cycles while streaming -> at most 2 words buffered, fifo_rd_en=0 while occ+inflight=2, m_data stable, no word lost.
REQ-033 SHALL cover: en dropped with occ=1 and inflight=1 -> state DRAIN, 2 more words delivered, then IDLE and busy=0, no further fifo_rd_en.
REQ-034 SHALL cover: fifo_empty toggling 1/0 every cycle -> fifo_rd_en never asserted while fifo_empty=1, and underflow_err stays 0.
REQ-035 SHALL cover: forced fifo_underflow=1 with inflight=1 -> underflow_err=1, word dropped, rd_count unchanged.
REQ-036 SHALL cover: rst_n=0 for 1 cycle mid-stream with occ=2 -> m_valid=0, rd_count=0 (0 also without FIFO_RD_COUNT_EN), state IDLE next cycle.
